// File: rtl/addsub_pkg.sv
// Shared constants, flag bundle and flag helper for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } flags_t;

    // Two's-complement overflow: like-signed operands giving an opposite-signed result.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle between the ALU operand registers, addsub_pipe and writeback.
interface addsub_pipe_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );

endinterface

// File: rtl/add_chunk.sv
// Combinational W-bit ripple-carry adder; one instance per pipeline stage of addsub_pipe.
module add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[W];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit carry-chained slice per stage,
// with a single global advance enable so the whole pipe stalls together under backpressure.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_pipe_if.slave bus
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             vld_out;
    logic [WIDTH-1:0] sum_q;
    flags_t           flags_q;

    assign en           = !vld_out || bus.out_ready;
    assign bus.in_ready = en;

    assign b_eff = (bus.sub == OP_SUB) ? ~bus.b   : bus.b;
    assign c0    = (bus.sub == OP_SUB) ? ~bus.cin : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Remaining unprocessed b_eff chunks (k..STAGES-1) entering this stage.
        localparam int YW = WIDTH - k * CHUNK;

        logic [WIDTH-1:0] xi;
        logic [WIDTH-1:0] xo;
        logic [YW-1:0]    yi;
        logic             ci;
        logic             vi;
        logic [CHUNK-1:0] s;
        logic             co;

        if (k == 0) begin : g_head
            assign xi = bus.a;
            assign yi = b_eff;
            assign ci = c0;
            assign vi = bus.in_valid;
        end else begin : g_link
            assign xi = g_stg[k-1].g_mid.x_p;
            assign yi = g_stg[k-1].g_mid.y_p;
            assign ci = g_stg[k-1].g_mid.carry_p;
            assign vi = g_stg[k-1].g_mid.vld_p;
        end

        add_chunk #(.W(CHUNK)) u_add (
            .a  (xi[k*CHUNK +: CHUNK]),
            .b  (yi[CHUNK-1:0]),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        // x word carries finished sum chunks below and untouched a chunks above.
        always_comb begin
            xo                     = xi;
            xo[k*CHUNK +: CHUNK]   = s;
        end

        if (k < STAGES - 1) begin : g_mid
            logic             vld_p;
            logic             carry_p;
            logic [WIDTH-1:0] x_p;
            logic [YW-CHUNK-1:0] y_p;

            // ---- stage k register boundary ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= 1'b0;
                end else if (en) begin
                    vld_p <= vi;
                end
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    x_p     <= xo;
                    y_p     <= yi[YW-1:CHUNK];
                    carry_p <= co;
                end
            end
        end else begin : g_tail
            // ---- final stage register boundary: result and flags ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_out <= 1'b0;
                    sum_q   <= '0;
                    flags_q <= '0;
                end else if (en) begin
                    vld_out          <= vi;
                    sum_q            <= xo;
                    flags_q.cout     <= co;
                    flags_q.overflow <= signed_ovf(xi[WIDTH-1], yi[YW-1], xo[WIDTH-1]);
                    flags_q.zero     <= ~|xo;
                end
            end
        end
    end

    assign bus.out_valid = vld_out;
    assign bus.sum       = sum_q;
    assign bus.cout      = flags_q.cout;
    assign bus.overflow  = flags_q.overflow;
    assign bus.zero      = flags_q.zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed vectors, random streams, backpressure and reset on
// three configurations (8/2, 32/4, 32/1) with an in-order scoreboard per instance.
module tb_addsub_pipe;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } rec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
        logic       z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    rec_t exp_q[3][$];
    rec_t obs_q[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_pipe_if #(.WIDTH(8))  b8  ();
    addsub_pipe_if #(.WIDTH(32)) b32 ();
    addsub_pipe_if #(.WIDTH(32)) b1  ();

    addsub_pipe #(.WIDTH(8),  .STAGES(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    addsub_pipe #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    addsub_pipe #(.WIDTH(32), .STAGES(1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));

    // Output monitor: record every consumed result beat with its cycle.
    always @(negedge clk) begin
        if (b8.out_valid && b8.out_ready)
            obs_q[0].push_back('{32'(b8.sum), b8.cout, b8.overflow, b8.zero, cyc});
        if (b32.out_valid && b32.out_ready)
            obs_q[1].push_back('{b32.sum, b32.cout, b32.overflow, b32.zero, cyc});
        if (b1.out_valid && b1.out_ready)
            obs_q[2].push_back('{b1.sum, b1.cout, b1.overflow, b1.zero, cyc});
    end

    function automatic int wid(input int d);
        return (d == 0) ? 8 : 32;
    endfunction

    function automatic int stg(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    function automatic logic rdy(input int d);
        case (d)
            0:       return b8.in_ready;
            1:       return b32.in_ready;
            default: return b1.in_ready;
        endcase
    endfunction

    // Reference: a + (sub ? ~b : b) + (sub ? ~cin : cin), evaluated wide.
    function automatic rec_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [63:0] m, aa, bb, full;
        rec_t r;
        m  = (64'd1 << w) - 64'd1;
        aa = {32'b0, a} & m;
        bb = {32'b0, b} & m;
        if (sub) bb = ~bb & m;
        full   = aa + bb + {63'b0, sub ^ cin};
        r.sum  = full[31:0] & m[31:0];
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        r.zero = (r.sum == 32'd0);
        r.cyc  = 0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        case (d)
            0: begin b8.in_valid = v;  b8.a = a[7:0]; b8.b = b[7:0]; b8.cin = cin; b8.sub = sub; end
            1: begin b32.in_valid = v; b32.a = a;     b32.b = b;     b32.cin = cin; b32.sub = sub; end
            default: begin b1.in_valid = v; b1.a = a; b1.b = b; b1.cin = cin; b1.sub = sub; end
        endcase
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Present one beat; returns once accepted (cycle in acc), bounded wait.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input rec_t e, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        drive(d, 1'b1, a, b, cin, sub);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy(d)) begin
                exp_q[d].push_back(e);
                acc = cyc;
                ok  = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL d%0d_accept: in_ready stayed 0, required 1 within 20 cycles", d);
        end
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 40; i++) begin
            if (obs_q[d].size() >= exp_q[d].size()) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic score(input int d, input string tag);
        rec_t o, e;
        check($sformatf("d%0d_%s_count", d, tag), 32'(obs_q[d].size()), 32'(exp_q[d].size()));
        while (obs_q[d].size() > 0 && exp_q[d].size() > 0) begin
            o = obs_q[d].pop_front();
            e = exp_q[d].pop_front();
            check($sformatf("d%0d_%s_sum", d, tag),  o.sum,        e.sum);
            check($sformatf("d%0d_%s_cout", d, tag), 32'(o.cout),  32'(e.cout));
            check($sformatf("d%0d_%s_ovf", d, tag),  32'(o.ovf),   32'(e.ovf));
            check($sformatf("d%0d_%s_zero", d, tag), 32'(o.zero),  32'(e.zero));
        end
        obs_q[d].delete();
        exp_q[d].delete();
    endtask

    task automatic stream(input int d, input int n);
        int a0, an, acc;
        logic [31:0] a, b;
        logic ci, sb;
        rec_t e;
        a0 = 0;
        an = 0;
        for (int i = 0; i < n; i++) begin
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            e  = model(wid(d), a, b, ci, sb);
            send(d, a, b, ci, sb, e, acc);
            if (i == 0) a0 = acc;
            an = acc;
        end
        idle(d);
        drain(d);
        check($sformatf("d%0d_stream_acc_span", d), 32'(an - a0), 32'(n - 1));
        check($sformatf("d%0d_stream_nout", d), 32'(obs_q[d].size()), 32'(n));
        if (obs_q[d].size() == n) begin
            check($sformatf("d%0d_stream_first_lat", d), 32'(obs_q[d][0].cyc - a0), 32'(stg(d)));
            check($sformatf("d%0d_stream_last_lat", d), 32'(obs_q[d][n-1].cyc - a0), 32'(n - 1 + stg(d)));
        end
        score(d, "stream");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[10];
        rec_t e, ea, eb, ec;
        int acc;

        tv[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0};
        tv[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        tv[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        tv[4] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0};
        tv[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        tv[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tv[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tv[9] = '{8'h01, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

        for (int d = 0; d < 3; d++) idle(d);
        b8.out_ready  = 1'b1;
        b32.out_ready = 1'b1;
        b1.out_ready  = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst8_out_valid", 32'(b8.out_valid), 32'd0);
        check("rst8_sum",       32'(b8.sum),       32'd0);
        check("rst8_cout",      32'(b8.cout),      32'd0);
        check("rst8_overflow",  32'(b8.overflow),  32'd0);
        check("rst8_zero",      32'(b8.zero),      32'd0);
        check("rst8_in_ready",  32'(b8.in_ready),  32'd1);
        check("rst32_out_valid", 32'(b32.out_valid), 32'd0);
        check("rst32_sum",       b32.sum,            32'd0);
        check("rst1_out_valid",  32'(b1.out_valid),  32'd0);
        check("rst1_sum",        b1.sum,             32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, first vector alone to measure latency
        for (int i = 0; i < 10; i++) begin
            e = '{32'(tv[i].s), tv[i].c, tv[i].o, tv[i].z, 0};
            send(0, 32'(tv[i].a), 32'(tv[i].b), tv[i].cin, tv[i].sub, e, acc);
            if (i == 0) begin
                idle(0);
                drain(0);
                if (obs_q[0].size() >= 1)
                    check("d0_single_latency", 32'(obs_q[0][0].cyc - acc), 32'd2);
                else
                    check("d0_single_latency_seen", 32'(obs_q[0].size()), 32'd1);
                score(0, "vec0");
            end
        end
        idle(0);
        drain(0);
        score(0, "vec");

        stream(0, 16);

        // Backpressure: stall with the pipe full, then release
        b8.out_ready = 1'b0;
        ea = model(8, 32'h12, 32'h34, 1'b0, 1'b0);
        eb = model(8, 32'h90, 32'h90, 1'b0, 1'b0);
        ec = model(8, 32'h01, 32'h02, 1'b0, 1'b1);
        send(0, 32'h12, 32'h34, 1'b0, 1'b0, ea, acc);
        send(0, 32'h90, 32'h90, 1'b0, 1'b0, eb, acc);
        drive(0, 1'b1, 32'h01, 32'h02, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready",  32'(b8.in_ready),  32'd0);
            check("bp_out_valid", 32'(b8.out_valid), 32'd1);
            check("bp_sum_hold",  32'(b8.sum),       ea.sum);
            check("bp_flag_hold", {29'b0, b8.cout, b8.overflow, b8.zero}, {29'b0, ea.cout, ea.ovf, ea.zero});
        end
        @(posedge clk);
        #1;
        b8.out_ready = 1'b1;
        send(0, 32'h01, 32'h02, 1'b0, 1'b1, ec, acc);
        idle(0);
        drain(0);
        score(0, "bp");

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) begin
            e = model(8, 32'(8'h21 + i), 32'h0F, 1'b0, 1'b0);
            send(0, 32'(8'h21 + i), 32'h0F, 1'b0, 1'b0, e, acc);
        end
        idle(0);
        #2;
        check("pre_rst_out_valid", 32'(b8.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(b8.out_valid), 32'd0);
        check("mid_rst_sum",       32'(b8.sum),       32'd0);
        exp_q[0].delete();
        obs_q[0].delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_stale",  32'(obs_q[0].size()), 32'd0);
        check("post_rst_out_valid", 32'(b8.out_valid),    32'd0);
        @(posedge clk);
        #1;
        e = model(8, 32'h55, 32'hAA, 1'b1, 1'b0);
        send(0, 32'h55, 32'hAA, 1'b1, 1'b0, e, acc);
        e = model(8, 32'h33, 32'h44, 1'b0, 1'b1);
        send(0, 32'h33, 32'h44, 1'b0, 1'b1, e, acc);
        idle(0);
        drain(0);
        score(0, "post_rst");

        stream(1, 16);
        stream(2, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined integer adder/subtractor; successor to the 4-bit ripple-carry adder used in the lab exercises.
- Splits a WIDTH-bit operation into STAGES equal carry-chained chunks, one chunk per pipeline stage.
- Uses a valid/ready handshake on input and output, and produces carry, signed-overflow and zero flags.
- Sits between operand registers and the result/flag writeback in the lab ALU datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES
STAGES, 4, number of pipeline stages = number of chunks; 1 <= STAGES <= WIDTH
CHUNK, WIDTH/STAGES, derived local constant; bits per chunk, not overridable

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: A+B+cin; 1: A-B-cin
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  add: carry out; sub: 1 = no borrow
overflow  output  1  two's-complement signed overflow
zero  output  1  sum == 0

Behaviour:
- Reset (async assert, sync release): every stage valid bit = 0; out_valid = 0; sum = 0; cout = 0; overflow = 0; zero = 0. Data registers need not be cleared beyond the outputs listed.
- Effective operands:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - The result is a + b_eff + c0, so sub=1 yields a - b - cin.
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational).
- Transfer rules:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
- When en = 1, all stages shift together.
  - Stage k (0-based) adds chunk k of a and b_eff with the carry from stage k-1 (c0 for k = 0).
  - It registers the chunk sum and carry.
  - Unprocessed upper chunks and already-computed lower sum chunks travel skewed alongside.
- When en = 0, every stage holds. No stage advances independently, so bubbles are not squeezed out.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready stays high. Throughput: 1 beat/cycle.
- A bubble (in_valid = 0 while en = 1) inserts a stage with valid = 0. Outputs for an invalid final stage are don't-care except out_valid = 0.
- Flags are registered with the final stage:
  - cout = carry out of the top chunk.
  - overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]); carry a[W-1] and b_eff[W-1] down the pipe for this.
  - zero = ~|sum.
- Output stability: sum and the flags hold unchanged while out_valid && !out_ready.
- Ordering: results emerge strictly in acceptance order, with no drops or duplicates.
- Reset mid-operation: all in-flight beats are discarded; out_valid drops asynchronously.
- STAGES = 1 degenerates to a single registered WIDTH-bit adder with latency 1.

Decomposition:
- Package addsub_pkg:
  - stage payload struct {valid, carry, a_hi, b_hi, sum_lo, a_msb, b_msb} parametrised via localparams;
  - opcode constants OP_ADD = 1'b0, OP_SUB = 1'b1.
- Sub-module add_chunk: combinational CHUNK-bit ripple adder (a, b, ci -> s, co). Instantiated STAGES times via generate.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1; a=0x3C, b=0x05, cin=0, sub=0 -> 2 cycles later: sum=0x41, cout=0, overflow=0, zero=0.
- Signed overflow: a=0x7F, b=0x01, add -> sum=0x80, overflow=1, cout=0. Carry: a=0xFF, b=0x01 -> sum=0x00, cout=1, zero=1, overflow=0.
- Subtract: a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0 (borrow). a=0x10, b=0x01, sub=1, cin=1 -> sum=0x0E, cout=1.
- Back-to-back stream of 16 random beats, out_ready=1:
  - one result per cycle after 2-cycle fill;
  - every result matches the reference model in order.
- Backpressure:
  - out_ready=0 for 5 cycles while the pipe is full -> in_ready=0, sum/flags stable, no beat lost;
  - release -> remaining beats drain in order.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, sum=0; after release only newly accepted beats appear. Repeat the stream test with WIDTH=32, STAGES=4 and STAGES=1.
